cache_miss_controller: RTL and testbench

//  Sequencing FSM for the 4-way set-associative cache built around the tag comparator.
//  - Presents the latched request tag/set and per-way invalid flags to the comparator.
//  - On a hit: acks the CPU.
//  - On a miss: picks a victim (first invalid way, else tree-PLRU), writes it back if

---
 rtl/cache_miss_controller.sv | 215 +++++++++++++++++++++
 tb/tb_cache_miss_controller.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_miss_controller
// Purpose  : Sequencing FSM for a 4-way set-associative cache built around an
//            external tag comparator. Latches the CPU request and drives the
//            comparator. On a hit it acknowledges the CPU. On a miss it picks a
//            victim (lowest invalid way, else tree-PLRU), writes the victim back
//            if it is dirty, refills the line and updates the tag array. Holds
//            the valid, dirty and PLRU state for every set.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            cpu_req/we/addr/ack      CPU side ({tag, set} address)
//            busy                     high whenever the FSM is not idle
//            cmp_tag/set/inv          to comparator and tag RAM
//            hit, hit_way, way_tags   from comparator and tag RAM
//            tag_we, tag_way          tag array write strobe / way
//            mem_req/we/addr/ack      memory side (we=1 writeback, we=0 refill)
//            hit_cnt, miss_cnt        saturating lookup statistics (optional)
// Options  : define CACHE_STATS_EN to add the hit_cnt / miss_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module cache_miss_controller #(
  parameter int TAG_W = 12,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [TAG_W+IDX_W-1:0] cpu_addr,
  output logic                   cpu_ack,
  output logic                   busy,
  output logic [TAG_W-1:0]       cmp_tag,
  output logic [IDX_W-1:0]       cmp_set,
  output logic [3:0]             cmp_inv,
  input  logic                   hit,
  input  logic [1:0]             hit_way,
  input  logic [4*TAG_W-1:0]     way_tags,
  output logic                   tag_we,
  output logic [1:0]             tag_way,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [TAG_W+IDX_W-1:0] mem_addr,
  input  logic                   mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]            hit_cnt,
  output logic [15:0]            miss_cnt
`endif
);

  localparam int SETS   = 2**IDX_W;
  localparam int ADDR_W = TAG_W + IDX_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_REFILL    = 3'd3,
    S_UPDATE    = 3'd4
  } state_t;

  state_t                 state_q;
  logic                   we_q;
  logic [TAG_W-1:0]       tag_q;
  logic [IDX_W-1:0]       set_q;
  logic [1:0]             victim_q;
  logic [SETS-1:0][3:0]   valid_q;
  logic [SETS-1:0][3:0]   dirty_q;
  logic [SETS-1:0][2:0]   plru_q;
  logic                   ack_q;
  logic                   tag_we_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [ADDR_W-1:0]      mem_addr_q;
`ifdef CACHE_STATS_EN
  logic [15:0]            hit_cnt_q;
  logic [15:0]            miss_cnt_q;
`endif

  // Per-set views of the latched set and the victim choice for a miss
  logic [3:0]             set_valid_d;
  logic [3:0]             set_dirty_d;
  logic [2:0]             set_plru_d;
  logic [1:0]             victim_d;
  logic [TAG_W-1:0]       victim_tag_d;

  // b0 points at the colder half, b1/b2 at the colder way inside each half
  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] r;
    r    = b;
    r[0] = ~w[1];
    if (w[1] == 1'b0) r[1] = ~w[0];
    else              r[2] = ~w[0];
    return r;
  endfunction

  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    if (b[0]) return b[2] ? 2'd3 : 2'd2;
    else      return b[1] ? 2'd1 : 2'd0;
  endfunction

  always_comb begin
    set_valid_d = valid_q[set_q];
    set_dirty_d = dirty_q[set_q];
    set_plru_d  = plru_q[set_q];
    victim_d    = plru_victim(set_plru_d);
    // Descending scan so the lowest-index invalid way wins over PLRU
    for (int w = 3; w >= 0; w--) begin
      if (!set_valid_d[w]) victim_d = 2'(w);
    end
    victim_tag_d = way_tags[int'(victim_d)*TAG_W +: TAG_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      tag_q      <= '0;
      set_q      <= '0;
      victim_q   <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      plru_q     <= '0;
      ack_q      <= 1'b0;
      tag_we_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
`endif
    end else begin
      ack_q    <= 1'b0;
      tag_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_req) begin
            tag_q   <= cpu_addr[ADDR_W-1:IDX_W];
            set_q   <= cpu_addr[IDX_W-1:0];
            we_q    <= cpu_we;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            ack_q          <= 1'b1;
            plru_q[set_q]  <= plru_touch(set_plru_d, hit_way);
            if (we_q) dirty_q[set_q][hit_way] <= 1'b1;
            state_q        <= S_IDLE;
`ifdef CACHE_STATS_EN
            if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
`endif
          end else begin
            victim_q  <= victim_d;
            mem_req_q <= 1'b1;
            if (set_valid_d[victim_d] && set_dirty_d[victim_d]) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= {victim_tag_d, set_q};
              state_q    <= S_WRITEBACK;
            end else begin
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag_q, set_q};
              state_q    <= S_REFILL;
            end
`ifdef CACHE_STATS_EN
            if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
`endif
          end
        end
        S_WRITEBACK: begin
          // mem_req stays high straight into the refill transfer
          if (mem_ack && mem_req_q) begin
            dirty_q[set_q][victim_q] <= 1'b0;
            mem_we_q                 <= 1'b0;
            mem_addr_q               <= {tag_q, set_q};
            state_q                  <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack && mem_req_q) begin
            mem_req_q <= 1'b0;
            tag_we_q  <= 1'b1;
            state_q   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          valid_q[set_q][victim_q] <= 1'b1;
          dirty_q[set_q][victim_q] <= we_q;
          plru_q[set_q]            <= plru_touch(set_plru_d, victim_q);
          ack_q                    <= 1'b1;
          state_q                  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_ack  = ack_q;
  assign busy     = (state_q != S_IDLE);
  assign cmp_tag  = tag_q;
  assign cmp_set  = set_q;
  assign cmp_inv  = ~set_valid_d;
  assign tag_we   = tag_we_q;
  assign tag_way  = victim_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
`ifdef CACHE_STATS_EN
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_miss_controller
// Purpose  : Self-checking bench for cache_miss_controller. Models the tag
//            comparator, tag RAM and a memory with programmable stalls; checks
//            a directed vector table, reset-during-writeback, and randomized
//            traffic against a behavioural cache model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_miss_controller;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic        cpu_ack;
  logic        busy;
  logic [11:0] cmp_tag;
  logic [1:0]  cmp_set;
  logic [3:0]  cmp_inv;
  logic        hit;
  logic [1:0]  hit_way;
  logic [47:0] way_tags;
  logic        tag_we;
  logic [1:0]  tag_way;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  cache_miss_controller #(.TAG_W(12), .IDX_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_ack  (cpu_ack),
    .busy     (busy),
    .cmp_tag  (cmp_tag),
    .cmp_set  (cmp_set),
    .cmp_inv  (cmp_inv),
    .hit      (hit),
    .hit_way  (hit_way),
    .way_tags (way_tags),
    .tag_we   (tag_we),
    .tag_way  (tag_way),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment: tag RAM, comparator, memory ----------------
  logic [11:0] tags [4][4];
  int          wb_stall;
  int          rf_stall;
  int          stall_cnt;

  always_ff @(posedge clk) begin
    if (tag_we) tags[cmp_set][tag_way] <= cmp_tag;
  end

  always_comb begin
    way_tags = '0;
    hit      = 1'b0;
    hit_way  = 2'd0;
    for (int w = 0; w < 4; w++) begin
      way_tags[w*12 +: 12] = tags[cmp_set][w];
      if (!cmp_inv[w] && tags[cmp_set][w] == cmp_tag) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
  end

  assign mem_ack = mem_req && (stall_cnt >= (mem_we ? wb_stall : rf_stall));

  always_ff @(posedge clk) begin
    stall_cnt <= (mem_req && !mem_ack) ? stall_cnt + 1 : 0;
  end

  // ---------------- bookkeeping ----------------
  int total;
  int bad;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected/observed description of one CPU transaction
  typedef struct {
    logic [13:0] addr;
    bit          we;
    int          wbs;
    int          rfs;
    bit          noise;
    int          lat;   // cycle of cpu_ack counting the LOOKUP cycle as 1
    int          nx;    // number of completed memory transfers
    logic [13:0] a0;
    bit          w0;
    logic [13:0] a1;
    int          tw;    // way written to tag array, -1 for a hit
    int          rq;    // cycles with mem_req high
  } vec_t;

  typedef struct {
    int          lat;
    int          nx;
    logic [13:0] a0;
    bit          w0;
    logic [13:0] a1;
    bit          w1;
    int          ntw;
    int          tw;
    int          rq;
    bit          stable;
    bit          idle_after;
  } obs_t;

  function automatic vec_t mkv(input logic [13:0] addr, input bit we, input int wbs, input int rfs,
                               input bit noise, input int lat, input int nx, input logic [13:0] a0,
                               input bit w0, input logic [13:0] a1, input int tw, input int rq);
    vec_t v;
    v.addr = addr; v.we = we; v.wbs = wbs; v.rfs = rfs; v.noise = noise;
    v.lat = lat; v.nx = nx; v.a0 = a0; v.w0 = w0; v.a1 = a1; v.tw = tw; v.rq = rq;
    return v;
  endfunction

  // ---------------- behavioural cache model ----------------
  logic [11:0] m_tag   [4][4];
  bit          m_valid [4][4];
  bit          m_dirty [4][4];
  bit          m_hi_pair_old [4];  // ways 2/3 were used less recently than 0/1
  bit          m_w1_old      [4];  // way 1 older than way 0
  bit          m_w3_old      [4];  // way 3 older than way 2

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_hi_pair_old[s] = 1'b0; m_w1_old[s] = 1'b0; m_w3_old[s] = 1'b0;
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0; m_tag[s][w] = '0;
      end
    end
  endtask

  task automatic model_use(input int s, input int w);
    m_hi_pair_old[s] = (w < 2);
    if (w < 2) m_w1_old[s] = (w == 0);
    else       m_w3_old[s] = (w == 2);
  endtask

  task automatic model_step(input logic [13:0] addr, input bit we, input int wbs, input int rfs,
                            input bit noise, output vec_t p);
    logic [11:0] t;
    int          s;
    int          hw;
    int          v;
    bit          wb;
    t  = addr[13:2];
    s  = int'(addr[1:0]);
    hw = -1;
    p  = mkv(addr, we, wbs, rfs, noise, 0, 0, '0, 1'b0, '0, -1, 0);
    for (int w = 0; w < 4; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    if (hw >= 0) begin
      p.lat = 2;
      model_use(s, hw);
      if (we) m_dirty[s][hw] = 1'b1;
    end else begin
      v = -1;
      for (int w = 3; w >= 0; w--)
        if (!m_valid[s][w]) v = w;
      if (v < 0) v = m_hi_pair_old[s] ? (m_w3_old[s] ? 3 : 2) : (m_w1_old[s] ? 1 : 0);
      wb = m_valid[s][v] && m_dirty[s][v];
      if (wb) begin
        p.nx = 2; p.a0 = {m_tag[s][v], 2'(s)}; p.w0 = 1'b1; p.a1 = {t, 2'(s)};
      end else begin
        p.nx = 1; p.a0 = {t, 2'(s)}; p.w0 = 1'b0;
      end
      p.lat = 4 + rfs + (wb ? 1 + wbs : 0);
      p.rq  = 1 + rfs + (wb ? 1 + wbs : 0);
      p.tw  = v;
      m_tag[s][v] = t; m_valid[s][v] = 1'b1; m_dirty[s][v] = we;
      model_use(s, v);
    end
  endtask

  // ---------------- drivers / checkers ----------------
  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    wb_stall = 0; rf_stall = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_req(input logic [13:0] addr, input bit we, input int wbs, input int rfs,
                         input bit noise, output obs_t o);
    bit          pend;
    logic [13:0] paddr;
    bit          pwe;
    o = '{default: 0};
    o.lat = -1; o.stable = 1'b1;
    wb_stall = wbs; rf_stall = rfs;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = addr; cpu_we = we;
    @(negedge clk);
    // Optional noise: keep cpu_req high with junk while the request is in flight
    if (noise) begin cpu_addr = 14'($urandom); cpu_we = 1'($urandom); end
    else cpu_req = 1'b0;
    pend = 1'b0; paddr = '0; pwe = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (cyc == 2) cpu_req = 1'b0;
      if (pend && (!mem_req || mem_addr != paddr || mem_we != pwe)) o.stable = 1'b0;
      if (mem_req) begin
        o.rq++;
        if (mem_ack) begin
          if (o.nx == 0) begin o.a0 = mem_addr; o.w0 = mem_we; end
          else           begin o.a1 = mem_addr; o.w1 = mem_we; end
          o.nx++;
        end
      end
      pend = mem_req && !mem_ack; paddr = mem_addr; pwe = mem_we;
      if (tag_we) begin o.ntw++; o.tw = int'(tag_way); end
      if (cpu_ack) begin o.lat = cyc; break; end
      @(negedge clk);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    o.idle_after = !cpu_ack && !busy;
  endtask

  task automatic compare(input string id, input vec_t e, input obs_t o);
    chk({id, " latency"}, o.lat, e.lat);
    chk({id, " xfer_count"}, o.nx, e.nx);
    if (e.nx >= 1) begin
      chk({id, " xfer0_addr"}, int'(o.a0), int'(e.a0));
      chk({id, " xfer0_we"}, int'(o.w0), int'(e.w0));
    end
    if (e.nx == 2) begin
      chk({id, " xfer1_addr"}, int'(o.a1), int'(e.a1));
      chk({id, " xfer1_we"}, int'(o.w1), 0);
    end
    chk({id, " tag_we_pulses"}, o.ntw, (e.tw < 0) ? 0 : 1);
    if (e.tw >= 0) chk({id, " tag_way"}, o.tw, e.tw);
    chk({id, " req_cycles"}, o.rq, e.rq);
    chk({id, " addr_stable"}, int'(o.stable), 1);
    chk({id, " idle_after_ack"}, int'(o.idle_after), 1);
  endtask

  task automatic check_vs_model(input string id, input logic [13:0] addr, input bit we,
                                input int wbs, input int rfs, input bit noise);
    vec_t p;
    obs_t o;
    model_step(addr, we, wbs, rfs, noise, p);
    run_req(addr, we, wbs, rfs, noise, o);
    compare(id, p, o);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl [12];

  initial begin
    obs_t o;
    bit   found;
    bit   any;
    total = 0; bad = 0;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    wb_stall = 0; rf_stall = 0;

    // Directed sequence; address = {tag, set}
    tbl[0]  = mkv(14'h2AD, 0, 0, 0, 0,  4, 1, 14'h2AD, 0, 14'h000,  0, 1); // 0x0AB set1 miss
    tbl[1]  = mkv(14'h2AD, 0, 0, 0, 1,  2, 0, 14'h000, 0, 14'h000, -1, 0); // same: hit
    tbl[2]  = mkv(14'h400, 1, 0, 0, 0,  4, 1, 14'h400, 0, 14'h000,  0, 1); // fill set0 with writes
    tbl[3]  = mkv(14'h404, 1, 0, 0, 0,  4, 1, 14'h404, 0, 14'h000,  1, 1);
    tbl[4]  = mkv(14'h408, 1, 0, 0, 0,  4, 1, 14'h408, 0, 14'h000,  2, 1);
    tbl[5]  = mkv(14'h40C, 1, 0, 0, 0,  4, 1, 14'h40C, 0, 14'h000,  3, 1);
    tbl[6]  = mkv(14'h410, 0, 0, 0, 0,  5, 2, 14'h400, 1, 14'h410,  0, 2); // PLRU way0, writeback
    tbl[7]  = mkv(14'h410, 0, 0, 0, 0,  2, 0, 14'h000, 0, 14'h000, -1, 0); // hit
    tbl[8]  = mkv(14'h414, 0, 0, 5, 0, 10, 2, 14'h408, 1, 14'h414,  2, 7); // refill stalls 5
    tbl[9]  = mkv(14'h418, 0, 0, 0, 1,  5, 2, 14'h404, 1, 14'h418,  1, 2);
    tbl[10] = mkv(14'h41C, 0, 2, 0, 0,  7, 2, 14'h40C, 1, 14'h41C,  3, 4); // writeback stalls 2
    tbl[11] = mkv(14'h420, 0, 0, 0, 0,  4, 1, 14'h420, 0, 14'h000,  0, 1); // way0 clean: no writeback

    do_reset();
    chk("reset cpu_ack", int'(cpu_ack), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset cmp_inv", int'(cmp_inv), 4'hF);
    chk("reset cmp_tag", int'(cmp_tag), 0);
    chk("reset cmp_set", int'(cmp_set), 0);
    chk("reset tag_we", int'(tag_we), 0);
    chk("reset tag_way", int'(tag_way), 0);
    chk("reset mem_req", int'(mem_req), 0);
    chk("reset mem_we", int'(mem_we), 0);
    chk("reset mem_addr", int'(mem_addr), 0);
`ifdef CACHE_STATS_EN
    chk("reset hit_cnt", int'(hit_cnt), 0);
    chk("reset miss_cnt", int'(miss_cnt), 0);
`endif

    for (int i = 0; i < 12; i++) begin
      run_req(tbl[i].addr, tbl[i].we, tbl[i].wbs, tbl[i].rfs, tbl[i].noise, o);
      compare($sformatf("vec%0d", i), tbl[i], o);
    end

    // Reset while a writeback is outstanding
    do_reset();
    model_reset();
    for (int i = 0; i < 4; i++)
      check_vs_model($sformatf("rstfill%0d", i), {12'(12'h010 + i), 2'd2}, 1'b1, 0, 0, 1'b0);
    wb_stall = 3; rf_stall = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = {12'h014, 2'd2}; cpu_we = 1'b0;
    @(negedge clk);
    cpu_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req && mem_we) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_wb reached writeback", int'(found), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wb mem_req", int'(mem_req), 0);
    chk("rst_wb busy", int'(busy), 0);
    chk("rst_wb cmp_inv", int'(cmp_inv), 4'hF);
    chk("rst_wb cpu_ack", int'(cpu_ack), 0);
    rst = 1'b0;
    any = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any = any | cpu_ack | mem_req | busy;
    end
    chk("rst_wb quiet after reset", int'(any), 0);

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 80; i++)
      check_vs_model($sformatf("rnd%0d", i),
                     {12'($urandom_range(0, 5)), 2'($urandom_range(0, 3))},
                     1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom));

`ifdef CACHE_STATS_EN
    do_reset();
    model_reset();
    chk("stats cleared hit_cnt", int'(hit_cnt), 0);
    chk("stats cleared miss_cnt", int'(miss_cnt), 0);
    check_vs_model("st0", {12'h020, 2'd3}, 1'b0, 0, 0, 1'b0);
    check_vs_model("st1", {12'h021, 2'd3}, 1'b1, 0, 0, 1'b0);
    check_vs_model("st2", {12'h020, 2'd3}, 1'b0, 0, 0, 1'b0);
    check_vs_model("st3", {12'h021, 2'd3}, 1'b0, 0, 0, 1'b0);
    check_vs_model("st4", {12'h020, 2'd3}, 1'b1, 0, 0, 1'b0);
    chk("stats hit_cnt", int'(hit_cnt), 3);
    chk("stats miss_cnt", int'(miss_cnt), 2);
    do_reset();
    chk("stats after rst hit_cnt", int'(hit_cnt), 0);
    chk("stats after rst miss_cnt", int'(miss_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
